// File: rtl/q2_alu_seq.sv
// Bit-serial sequencer for the q2 1-bit ALU slice: clocks WIDTH LSB-first
// bit-steps through the external slice and rebuilds the accumulator from its output.
module q2_alu_seq #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic             cin_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc,
    output logic             flag_f,
    output logic             alu_a0,
    output logic             alu_x0,
    output logic             alu_x1,
    output logic             alu_f,
    output logic             alu_o0,
    output logic             alu_o1,
    input  logic             alu_out,
    input  logic             alu_cout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] x_r;
    logic             f_r;
    logic [CW-1:0]    cnt_r;
    logic [1:0]       op_r;
    logic             busy_r;
    logic             done_r;

    // Sequencer FSM with datapath registers; DONE accepts a new start for back-to-back ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= {WIDTH{1'b0}};
            x_r     <= {WIDTH{1'b0}};
            f_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            op_r    <= 2'b00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_r     <= operand;
                        op_r    <= op;
                        cnt_r   <= {CW{1'b0}};
                        f_r     <= cin_clr ? 1'b0 : f_r;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    // Zero fill of X makes alu_x1 read 0 on the final step (logical shift right).
                    a_r   <= {alu_out, a_r[WIDTH-1:1]};
                    x_r   <= {1'b0, x_r[WIDTH-1:1]};
                    f_r   <= alu_cout;
                    cnt_r <= cnt_r + CW'(1);
                    if (cnt_r == LAST_STEP) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign acc    = a_r;
    assign flag_f = f_r;

    assign alu_a0 = a_r[0];
    assign alu_x0 = x_r[0];
    assign alu_x1 = x_r[1];
    assign alu_f  = f_r;
    assign alu_o0 = op_r[0];
    assign alu_o1 = op_r[1];

endmodule

// File: tb/tb_q2_alu_seq.sv
// Scoreboard bench for q2_alu_seq with a behavioural model of the 1-bit ALU slice.
module tb_q2_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] operand;
    logic         cin_clr;
    logic         busy, done, flag_f;
    logic [W-1:0] acc;
    logic         alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1;
    logic         alu_out, alu_cout;

    typedef struct {
        logic [W-1:0] a;
        logic         f;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    logic [W-1:0] m_a;
    logic         m_f;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    q2_alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
        .cin_clr(cin_clr), .busy(busy), .done(done), .acc(acc), .flag_f(flag_f),
        .alu_a0(alu_a0), .alu_x0(alu_x0), .alu_x1(alu_x1), .alu_f(alu_f),
        .alu_o0(alu_o0), .alu_o1(alu_o1), .alu_out(alu_out), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Cycle counter used to check start-to-done latency.
    always @(posedge clk) cyc <= cyc + 1;

    // ALU slice contract; returns {cout, out}.
    function automatic logic [1:0] slice(input logic [1:0] o, input logic a0,
                                         input logic x0, input logic x1, input logic f);
        logic r;
        case (o)
            2'b00:   return {f & ~x0, x0};
            2'b01:   begin r = ~(a0 | x0); return {f & ~r, r}; end
            2'b10:   return {(a0 & x0) | (a0 & f) | (x0 & f), a0 ^ x0 ^ f};
            default: return {f, x1};
        endcase
    endfunction

    // Slice model wired beside the sequencer.
    always_comb {alu_cout, alu_out} = slice({alu_o1, alu_o0}, alu_a0, alu_x0, alu_x1, alu_f);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive a start from a negedge, then predict the result and push it.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic cl);
        logic [W-1:0] xs;
        logic [1:0]   r;
        exp_t         e;
        start = 1'b1; op = o; operand = x; cin_clr = cl;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = 2'bxx; operand = 8'h00; cin_clr = 1'b0;
        if (cl) m_f = 1'b0;
        xs = x;
        for (int i = 0; i < W; i++) begin
            r   = slice(o, m_a[0], xs[0], xs[1], m_f);
            m_a = {r[0], m_a[W-1:1]};
            xs  = {1'b0, xs[W-1:1]};
            m_f = r[1];
        end
        e.a = m_a; e.f = m_f; e.cyc = cyc + W;
        sb.push_back(e);
    endtask

    // Full operation; returns at the negedge of the done cycle. poke re-asserts start mid-op.
    task automatic run(input logic [1:0] o, input logic [W-1:0] x, input logic cl, input bit poke);
        issue(o, x, cl);
        for (int i = 0; i < W; i++) begin
            check("busy_shift", busy, 1'b1);
            if (i == 0) check("alu_op", {alu_o1, alu_o0}, o);
            if (poke && i >= 2 && i <= 4) begin
                start = 1'b1; op = 2'b10; operand = 8'hFF; cin_clr = 1'b1;
            end else begin
                start = 1'b0; cin_clr = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; cin_clr = 1'b0;
        check("busy_done", busy, 1'b0);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest prediction.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("done_unexpected", done, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("acc", acc, mon_e.a);
                check("flag_f", flag_f, mon_e.f);
                check("done_cycle", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; operand = 8'h00; cin_clr = 1'b0;
        m_a = 8'h00; m_f = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acc", acc, 8'h00);
        check("rst_flag", flag_f, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_alu_op", {alu_o1, alu_o0}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        // Pass, ADD with and without carry-out.
        run(2'b00, 8'hA5, 1'b1, 1'b0); @(negedge clk);
        run(2'b00, 8'h35, 1'b1, 1'b0); @(negedge clk);
        run(2'b10, 8'h4A, 1'b1, 1'b0); @(negedge clk);
        run(2'b00, 8'hFF, 1'b1, 1'b0); @(negedge clk);
        run(2'b10, 8'h01, 1'b1, 1'b0); @(negedge clk);

        // Shift right keeps F=1 while loading A=0x10, then carry-in chain ADD.
        run(2'b11, 8'h20, 1'b0, 1'b0); @(negedge clk);
        run(2'b10, 8'h00, 1'b0, 1'b0); @(negedge clk);

        // NOR, then shift right with F=1 (set by a back-to-back ADD).
        run(2'b00, 8'h0F, 1'b1, 1'b0); @(negedge clk);
        run(2'b01, 8'h33, 1'b0, 1'b0); @(negedge clk);
        run(2'b00, 8'hFF, 1'b1, 1'b0);
        run(2'b10, 8'h01, 1'b1, 1'b0); @(negedge clk);
        run(2'b11, 8'h96, 1'b0, 1'b0); @(negedge clk);

        // Start while busy is ignored; start held in done cycle chains ops.
        run(2'b00, 8'h3C, 1'b1, 1'b1); @(negedge clk);
        run(2'b10, 8'h11, 1'b0, 1'b0);
        run(2'b10, 8'h22, 1'b0, 1'b0); @(negedge clk);

        // Asynchronous reset at bit-step 4 of an ADD.
        issue(2'b10, 8'h5A, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_acc", acc, 8'h00);
        check("midrst_flag", flag_f, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        void'(sb.pop_back());
        m_a = 8'h00; m_f = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        run(2'b10, 8'h81, 1'b0, 1'b0); @(negedge clk);
        run(2'b01, 8'h0C, 1'b1, 1'b0); @(negedge clk);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/q2_alu_seq.md
Name: q2_alu_seq

Overview:
- Bit-serial sequencer for the q2 1-bit ALU slice (ALU slice = separate module, instanced beside this block).
- Holds accumulator A, operand shift register X and carry flag F. On a start request it clocks WIDTH bit-steps through the slice, LSB first, and rebuilds A from alu_out.
- Sits between the q2 control unit (start/done handshake) and the ALU slice.

Parameters:
- WIDTH, 8, data word width in bits (>=2).
- CW, $clog2(WIDTH+1), bit-step counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  operation request, sampled in IDLE or DONE only.
- op  in  2  operation: 00 pass X, 01 NOR, 10 ADD with carry, 11 shift right.
- operand  in  WIDTH  X value, captured with start.
- cin_clr  in  1  with start: clear F before the first bit-step.
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse: operation complete, acc/flag_f valid.
- acc  out  WIDTH  accumulator A.
- flag_f  out  1  carry flag F.
- alu_a0, alu_x0, alu_x1, alu_f, alu_o0, alu_o1  out  1 each  drive to the ALU slice.
- alu_out, alu_cout  in  1 each  ALU slice result and carry.

Behaviour:
- Reset (rst_n low, async): state=IDLE, A=0, X=0, F=0, cnt=0, op_q=00, busy=0, done=0.
- ALU slice drive (combinational from registers):
  - alu_a0=A[0], alu_x0=X[0], alu_x1=X[1], alu_f=F, {alu_o1,alu_o0}=op_q.
- ALU slice contract (used by the bench model):
  - op 00: out=x0, cout=f&~out.
  - op 01: out=~(a0|x0), cout=f&~out.
  - op 10: out=a0^x0^f, cout=maj(a0,x0,f).
  - op 11: out=x1, cout=f.
- State IDLE: busy=0, done=0.
  - start=1 at an edge: X<=operand, op_q<=op, cnt<=0, F<=cin_clr?0:F, next state=SHIFT.
  - A is untouched by start.
- State SHIFT: busy=1. Each edge performs one bit-step:
  - A<={alu_out, A[WIDTH-1:1]}.
  - X<={1'b0, X[WIDTH-1:1]}; zero fill makes alu_x1=0 on the last step, giving a logical shift right for op 11.
  - F<=alu_cout.
  - cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: next state=DONE.
- State DONE: held for exactly one cycle. done=1, busy=0. acc=final result, flag_f=final carry.
  - start=1 here is accepted as in IDLE (back-to-back ops, no idle gap) and the next state is SHIFT.
  - Otherwise the next state is IDLE.
- Latency:
  - start sampled at edge 0; bit-steps occur on edges 1..WIDTH; done is high during the cycle after edge WIDTH.
  - Start-to-done = WIDTH+1 cycles. Throughput = one op per WIDTH+1 cycles.
- start while busy (SHIFT): ignored; op, operand and cin_clr are not captured.
- acc and flag_f are registered and change only on bit-step edges, on the start edge (F only, when cin_clr=1), or on reset.
- Reset mid-operation: immediate return to IDLE with all registers cleared. A partial result is never reported and done is never asserted.
- Unknown/X on op while in IDLE has no effect unless start=1.
- F persists across operations unless cin_clr=1 (multi-word add chains).

Test Plan:
- Reset, then start op=00 operand=0xA5 cin_clr=1 -> done 9 cycles after start, acc=0xA5, flag_f=0, busy high for 8 cycles.
- A=0x35, then start op=10 operand=0x4A cin_clr=1 -> acc=0x7F, flag_f=0. Next, A=0xFF, op=10 operand=0x01 cin_clr=1 -> acc=0x00, flag_f=1.
- Carry chain: after the previous op (F=1), load A=0x10, start op=10 operand=0x00 cin_clr=0 -> acc=0x11, flag_f=0.
- A=0x0F, F=0, start op=01 operand=0x33 -> acc=0xC0, flag_f=0. Separately, start op=11 operand=0x96 with F=1 -> acc=0x4B, flag_f=1.
- Start asserted again on cycles 3-5 of a running op with operand=0xFF -> ignored, result unchanged. Start held during the done cycle -> new op begins, busy high the next cycle.
- rst_n pulled low at bit-step 4 of an ADD -> acc=0, flag_f=0, busy=0 asynchronously. done is not pulsed, and the next op after reset runs normally.
